clint_timer_bank: RTL and testbench
===================================

Name: clint_timer_bank

Overview:
- Parametrised machine-timer/software-interrupt block for HART_NUM harts.
- mtime is free-running and advances on a programmable prescaled tick; it is not purely software-written.
- Per-hart mtimecmp and msip are accessed through a valid/ready register port with byte strobes and a one-cycle read response.
- Drives registered mtip/msip vectors to each hart's interrupt controller.

Parameters:
- HART_NUM, 1, number of harts (1..16); sizes the msip, mtimecmp and mtip arrays.
- TICK_DIV, 1, clk cycles per mtime increment (1..65535); 1 means increment every cycle.
- ADDR_W, 16, request address width (byte address).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid and ready are both high
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address; bits [2:0] ignored (8-byte aligned)
- req_wdata  in  64  write data
- req_wstrb  in  8  byte enables for writes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  64  read data (0 for writes)
- rsp_err  out  1  unmapped address
- mtime  out  64  current mtime
- mtip  out  HART_NUM  timer interrupt pending per hart
- msip  out  HART_NUM  software interrupt pending per hart

Behaviour:
- Reset values:
  - mtime = 0, prescaler = 0.
  - Every mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, so no spurious mtip.
  - msip = 0, mtip = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Reset wins over every other event in the same cycle. Reset asserted with a response pending drops rsp_valid the next cycle; the transaction is lost.
- Address map (byte offsets):
  - msip[h] at 0x0000 + 4*h. Even h uses bit 0 of the 8-byte word, enabled by wstrb[0]. Odd h uses bit 32, enabled by wstrb[4].
  - mtimecmp[h] at 0x4000 + 8*h.
  - mtime at 0xBFF8.
  - Any other address, or a hart index ≥ HART_NUM, is unmapped.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready. One outstanding transaction at a time.
  - An accepted request produces rsp_valid on the next cycle.
  - rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready.
- Reads:
  - Return register contents as of the accept cycle, before that cycle's tick.
  - An msip word returns both harts' bits in positions 0 and 32; unused bits read 0.
  - Unmapped reads return rdata = 0, err = 1.
- Writes:
  - Take effect at the end of the accept cycle, byte-granular per wstrb.
  - wstrb = 0 is a legal no-op with err = 0.
  - Unmapped writes change nothing and respond with err = 1.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - A tick is the cycle in which the count equals TICK_DIV-1.
  - On a tick, mtime <= mtime + 1, modulo 2^64 (all-ones wraps to 0).
- Collision: an mtime write in a tick cycle wins. Written bytes take wdata, unwritten bytes keep the current pre-increment value, and there is no increment that cycle. The prescaler is not reset by an mtime write.
- mtip[h] is registered: mtip[h] <= (mtime >= mtimecmp[h]), an unsigned 64-bit compare on the current register values. mtip therefore lags an mtime/mtimecmp change by one cycle.
- The msip output is the register value directly.

Optional Feature:
- Macro: CLINT_DEBUG_STOP_EN.
- When defined:
  - Adds input dbg_halt (1 bit).
  - While dbg_halt = 1, the prescaler and mtime increment freeze; register writes to mtime are still honoured.
  - Counting resumes from the frozen prescaler value when dbg_halt falls.
- When undefined: no port; mtime always counts.

Test Plan:
- Reset, TICK_DIV=4, idle 12 cycles -> mtime = 3 (ticks on cycles 4, 8, 12); all mtip = 0; read 0x4000 returns 64'hFFFF_FFFF_FFFF_FFFF, err = 0.
- Write mtimecmp[0] = 10, TICK_DIV=1, mtime starting at 0 -> mtip[0] rises exactly one cycle after mtime reaches 10. Write mtimecmp[0] = 100 -> mtip[0] falls the following cycle.
- HART_NUM=2: write 0x0000 with wdata bit32 = 1, wstrb = 8'hF0 -> msip = 2'b10. Read back rdata = 64'h1_0000_0000.
- mtime write 64'hFFFF_FFFF_FFFF_FFFF with wstrb = 8'hFF landing on a tick cycle -> mtime holds all-ones (no increment). At the next tick mtime wraps to 0.
- Hold rsp_ready = 0 after a read of 0xBFF8 -> req_ready = 0 and rsp_rdata stable for 5 cycles. Read of 0x8000 -> rsp_err = 1, rdata = 0.
- (CLINT_DEBUG_STOP_EN) dbg_halt high for 20 cycles at TICK_DIV=1 -> mtime unchanged throughout. After release it resumes +1 per cycle.

Source files
------------

// File: rtl/clint_timer_bank.sv
// clint_timer_bank: machine timer and software-interrupt bank for HART_NUM harts.
// mtime advances once every TICK_DIV clocks; per-hart mtimecmp/msip and mtime are
// reachable through a valid/ready register port with byte strobes.
// Build option: define CLINT_DEBUG_STOP_EN to add dbg_halt, which freezes counting.
module clint_timer_bank #(
    parameter int HART_NUM = 1,
    parameter int TICK_DIV = 1,
    parameter int ADDR_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
`ifdef CLINT_DEBUG_STOP_EN
    input  logic                dbg_halt,
`endif
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [63:0]         req_wdata,
    input  logic [7:0]          req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [63:0]         rsp_rdata,
    output logic                rsp_err,
    output logic [63:0]         mtime,
    output logic [HART_NUM-1:0] mtip,
    output logic [HART_NUM-1:0] msip
);
    // Addresses are decoded on 8-byte word indices.
    localparam int AW = ADDR_W - 3;
    localparam logic [AW-1:0] MTIME_W  = AW'(32'h0000_BFF8 >> 3);
    localparam logic [15:0]   DIV_LAST = 16'(TICK_DIV - 1);

    genvar gi;

    logic [15:0]         presc_q, presc_d;
    logic [63:0]         mtime_q, mtime_d;
    logic [63:0]         mtimecmp_q [HART_NUM];
    logic [63:0]         mtimecmp_d [HART_NUM];
    logic [HART_NUM-1:0] msip_q, msip_d;
    logic [HART_NUM-1:0] mtip_q, mtip_d;
    logic                rsp_valid_q;
    logic [63:0]         rsp_rdata_q;
    logic                rsp_err_q;

    logic                run;
    logic                tick;
    logic [AW-1:0]       word;
    logic                accept;
    logic                wr_en;
    logic [63:0]         wmask;
    logic                hit_mtime;
    logic [HART_NUM-1:0] hit_msip;
    logic [HART_NUM-1:0] hit_cmp;
    logic [63:0]         rd_part [HART_NUM];
    logic [63:0]         rd_data;
    logic                mapped;
    logic                addr_lsb_unused;

`ifdef CLINT_DEBUG_STOP_EN
    assign run = !dbg_halt;
`else
    assign run = 1'b1;
`endif

    assign tick            = run && (presc_q == DIV_LAST);
    assign word            = req_addr[ADDR_W-1:3];
    assign addr_lsb_unused = ^req_addr[2:0];
    assign req_ready       = !rsp_valid_q || rsp_ready;
    assign accept          = req_valid && req_ready;
    assign wr_en           = accept && req_write;
    assign hit_mtime       = (word == MTIME_W);
    assign mapped          = hit_mtime || (|hit_msip) || (|hit_cmp);

    // Expand byte strobes to a bit mask for read-modify-write merges.
    for (gi = 0; gi < 8; gi++) begin : g_mask
        assign wmask[gi*8 +: 8] = {8{req_wstrb[gi]}};
    end

    // Per-hart decode, next-state and read contribution. Harts 2k and 2k+1 share
    // one msip word: even hart in bit 0 (wstrb[0]), odd hart in bit 32 (wstrb[4]).
    for (gi = 0; gi < HART_NUM; gi++) begin : g_hart
        localparam int BITP = (gi % 2) * 32;
        localparam int STRB = (gi % 2) * 4;

        assign hit_msip[gi]   = (word == AW'(gi / 2));
        assign hit_cmp[gi]    = (word == AW'(32'h800 + gi));
        assign mtimecmp_d[gi] = (wr_en && hit_cmp[gi])
                              ? ((mtimecmp_q[gi] & ~wmask) | (req_wdata & wmask))
                              : mtimecmp_q[gi];
        assign msip_d[gi]     = (wr_en && hit_msip[gi] && req_wstrb[STRB])
                              ? req_wdata[BITP] : msip_q[gi];
        assign mtip_d[gi]     = (mtime_q >= mtimecmp_q[gi]);
        assign rd_part[gi]    = (hit_cmp[gi] ? mtimecmp_q[gi] : 64'd0)
                              | (hit_msip[gi] ? (64'(msip_q[gi]) << BITP) : 64'd0);
    end

    // Read mux: at most one source is selected, so OR-combining is sufficient.
    always_comb begin
        rd_data = hit_mtime ? mtime_q : 64'd0;
        for (int h = 0; h < HART_NUM; h++) begin
            rd_data = rd_data | rd_part[h];
        end
    end

    // Prescaler and mtime next state; an mtime write overrides that cycle's tick.
    always_comb begin
        presc_d = presc_q;
        if (run) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
        end
        mtime_d = mtime_q;
        if (wr_en && hit_mtime) begin
            mtime_d = (mtime_q & ~wmask) | (req_wdata & wmask);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // Timer state, per-hart registers and registered interrupt outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= 16'd0;
            mtime_q <= 64'd0;
            msip_q  <= '0;
            mtip_q  <= '0;
            for (int h = 0; h < HART_NUM; h++) begin
                mtimecmp_q[h] <= '1;
            end
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    // Response register: loaded on accept, held until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (req_write || !mapped) ? 64'd0 : rd_data;
            rsp_err_q   <= !mapped;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mtime     = mtime_q;
    assign mtip      = mtip_q;
    assign msip      = msip_q;

endmodule

// File: tb/tb_clint_timer_bank.sv
// Testbench for clint_timer_bank (HART_NUM=3, TICK_DIV=4): directed vector table,
// hand-written timing sequences and randomized traffic against a reference model.
module tb_clint_timer_bank;
    localparam int H  = 3;
    localparam int TD = 4;
`ifdef CLINT_DEBUG_STOP_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_halt;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_ready;
    wire         req_ready;
    wire         rsp_valid;
    wire  [63:0] rsp_rdata;
    wire         rsp_err;
    wire  [63:0] mtime;
    wire  [H-1:0] mtip;
    wire  [H-1:0] msip;

    always #5 clk = ~clk;

    clint_timer_bank #(.HART_NUM(H), .TICK_DIV(TD), .ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CLINT_DEBUG_STOP_EN
        .dbg_halt  (dbg_halt),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mtime     (mtime),
        .mtip      (mtip),
        .msip      (msip)
    );

    // Reference model state
    logic [63:0] m_mtime;
    logic [63:0] m_cmp [H];
    logic [H-1:0] m_msip;
    logic [H-1:0] m_mtip;
    int unsigned m_run;      // running (non-halted) cycles since reset
    logic        m_rv;
    logic [63:0] m_rd;
    logic        m_re;
    bit          m_just_reset;

    int n_compared = 0;
    int n_mismatch = 0;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [63:0] exp_rd;
        bit          exp_err;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] strb_mask(input logic [7:0] s);
        logic [63:0] m;
        for (int i = 0; i < 64; i++) m[i] = s[i / 8];
        return m;
    endfunction

    // One clock: predict from the rules, let the DUT clock, then compare.
    task automatic step();
        logic rdy, acc, tick, halt_e;
        int a, h, kind;
        logic [63:0] rv, mask;
        logic [63:0] x_mtime;
        logic [63:0] x_cmp [H];
        logic [H-1:0] x_msip, x_mtip;
        int unsigned x_run;
        logic x_rv, x_re;
        logic [63:0] x_rd;

        @(negedge clk);
        halt_e = HALT_EN && dbg_halt;
        rdy = !m_rv || rsp_ready;
        chk("req_ready", 64'(req_ready), 64'(rdy));
        acc  = req_valid && rdy;
        tick = !halt_e && ((m_run % TD) == TD - 1);

        x_mtime = tick ? m_mtime + 64'd1 : m_mtime;
        x_cmp   = m_cmp;
        x_msip  = m_msip;
        for (int k = 0; k < H; k++) x_mtip[k] = (m_mtime >= m_cmp[k]);
        x_run = halt_e ? m_run : m_run + 1;
        x_rv = m_rv; x_rd = m_rd; x_re = m_re;

        if (acc) begin
            a = int'({req_addr[15:3], 3'b000});
            kind = 0; h = 0;
            if (a < 'h4000) begin
                h = a / 4;
                if (h < H) kind = 1;
            end else if (a < 'h4000 + 8 * H) begin
                h = (a - 'h4000) / 8;
                kind = 2;
            end else if (a == 'hBFF8) begin
                kind = 3;
            end
            rv = 64'd0;
            if (kind == 1) begin
                rv = 64'(m_msip[h]);
                if (h + 1 < H) rv = rv | (64'(m_msip[h + 1]) << 32);
            end else if (kind == 2) begin
                rv = m_cmp[h];
            end else if (kind == 3) begin
                rv = m_mtime;
            end
            mask = strb_mask(req_wstrb);
            if (req_write) begin
                if (kind == 1) begin
                    if (req_wstrb[0]) x_msip[h] = req_wdata[0];
                    if (h + 1 < H && req_wstrb[4]) x_msip[h + 1] = req_wdata[32];
                end else if (kind == 2) begin
                    x_cmp[h] = (m_cmp[h] & ~mask) | (req_wdata & mask);
                end else if (kind == 3) begin
                    x_mtime = (m_mtime & ~mask) | (req_wdata & mask);
                end
            end
            x_rv = 1'b1;
            x_re = (kind == 0);
            x_rd = (req_write || kind == 0) ? 64'd0 : rv;
        end else if (rsp_ready) begin
            x_rv = 1'b0;
        end

        if (rst) begin
            x_mtime = 64'd0; x_msip = '0; x_mtip = '0; x_run = 0;
            for (int k = 0; k < H; k++) x_cmp[k] = '1;
            x_rv = 1'b0; x_rd = 64'd0; x_re = 1'b0;
        end

        @(posedge clk);
        m_mtime = x_mtime; m_cmp = x_cmp; m_msip = x_msip; m_mtip = x_mtip;
        m_run = x_run; m_rv = x_rv; m_rd = x_rd; m_re = x_re;
        m_just_reset = rst;
        #1;
        chk("mtime", mtime, m_mtime);
        chk("mtip", 64'(mtip), 64'(m_mtip));
        chk("msip", 64'(msip), 64'(m_msip));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
        if (m_rv || m_just_reset) begin
            chk("rsp_rdata", rsp_rdata, m_rd);
            chk("rsp_err", 64'(rsp_err), 64'(m_re));
        end
    endtask

    task automatic add(input bit wr, input logic [15:0] addr, input logic [63:0] wd,
                       input logic [7:0] st, input logic [63:0] rd, input bit er);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wd; v.strb = st; v.exp_rd = rd; v.exp_err = er;
        tbl.push_back(v);
    endtask

    task automatic issue(input bit wr, input logic [15:0] addr, input logic [63:0] wd,
                         input logic [7:0] st);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = st;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [63:0] target;
        logic [63:0] held;
        logic [15:0] addrs [12];

        rst = 1'b1; dbg_halt = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
        m_mtime = '0; m_msip = '0; m_mtip = '0; m_run = 0;
        m_rv = 1'b0; m_rd = '0; m_re = 1'b0; m_just_reset = 1'b0;
        for (int k = 0; k < H; k++) m_cmp[k] = '1;
        repeat (2) @(posedge clk);
        #1;
        step();
        chk("reset_rsp_rdata", rsp_rdata, 64'd0);
        chk("reset_mtip", 64'(mtip), 64'd0);
        rst = 1'b0;

        // Idle 12 cycles: ticks on cycles 4, 8, 12.
        repeat (12) step();
        chk("idle12_mtime", mtime, 64'd3);
        chk("idle12_mtip", 64'(mtip), 64'd0);

        // Directed vector table.
        add(0, 16'h4000, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        add(0, 16'h4010, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        add(0, 16'h4018, 64'd0, 8'h00, 64'd0, 1);
        add(0, 16'h0000, 64'd0, 8'h00, 64'd0, 0);
        add(1, 16'h0000, 64'h1_0000_0000, 8'hF0, 64'd0, 0);
        add(0, 16'h0000, 64'd0, 8'h00, 64'h1_0000_0000, 0);
        add(0, 16'h0004, 64'd0, 8'h00, 64'h1_0000_0000, 0);
        add(1, 16'h0008, 64'h1, 8'h01, 64'd0, 0);
        add(0, 16'h0008, 64'd0, 8'h00, 64'h1, 0);
        add(0, 16'h0010, 64'd0, 8'h00, 64'd0, 1);
        add(1, 16'h4008, 64'h1122_3344_5566_7788, 8'h0F, 64'd0, 0);
        add(0, 16'h4008, 64'd0, 8'h00, 64'hFFFF_FFFF_5566_7788, 0);
        add(1, 16'h4008, 64'h0, 8'h00, 64'd0, 0);
        add(0, 16'h400C, 64'd0, 8'h00, 64'hFFFF_FFFF_5566_7788, 0);
        add(1, 16'h8000, 64'h5, 8'hFF, 64'd0, 1);
        add(0, 16'h8000, 64'd0, 8'h00, 64'd0, 1);
        add(1, 16'h0000, 64'h0, 8'h0F, 64'd0, 0);
        add(0, 16'h0000, 64'd0, 8'h00, 64'h1_0000_0000, 0);
        add(1, 16'h0000, 64'h1, 8'h01, 64'd0, 0);
        add(0, 16'h0000, 64'd0, 8'h00, 64'h1_0000_0001, 0);
        foreach (tbl[i]) begin
            issue(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb);
            rsp_ready = 1'b1;
            step();
            req_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", i), 64'(rsp_valid), 64'd1);
            chk($sformatf("tbl%0d_rdata", i), rsp_rdata, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), 64'(rsp_err), 64'(tbl[i].exp_err));
            $display("txn tbl%0d wr=%0d addr=%h rdata=%h err=%0d", i, tbl[i].wr,
                     tbl[i].addr, rsp_rdata, rsp_err);
            step();
        end
        chk("tbl_msip_vec", 64'(msip), 64'b111);

        // mtip rises one cycle after mtime reaches mtimecmp[0].
        target = m_mtime + 64'd3;
        issue(1, 16'h4000, target, 8'hFF);
        step();
        req_valid = 1'b0;
        step();
        for (int k = 0; k < 40 && mtime != target; k++) step();
        chk("mtip_reach", mtime, target);
        chk("mtip_lag", 64'(mtip[0]), 64'd0);
        step();
        chk("mtip_rise", 64'(mtip[0]), 64'd1);
        issue(1, 16'h4000, 64'hFFFF_0000, 8'hFF);
        step();
        req_valid = 1'b0;
        chk("mtip_hold_on_write", 64'(mtip[0]), 64'd1);
        step();
        chk("mtip_fall", 64'(mtip[0]), 64'd0);
        $display("txn mtip sequence target=%h", target);

        // mtime write landing on a tick cycle: write wins, then wrap at next tick.
        for (int k = 0; k < 10 && (m_run % TD) != TD - 1; k++) step();
        issue(1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        step();
        req_valid = 1'b0;
        chk("coll_mtime", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (TD - 1) step();
        chk("coll_hold", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("coll_wrap", mtime, 64'd0);
        $display("txn collision mtime=%h", mtime);

        // Backpressure: response held for 5 cycles, no new accept.
        issue(0, 16'hBFF8, 64'd0, 8'h00);
        step();
        held = m_rd;
        rsp_ready = 1'b0;
        issue(0, 16'h4000, 64'd0, 8'h00);
        repeat (5) begin
            step();
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_rdata", rsp_rdata, held);
        end
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        $display("txn backpressure rdata=%h", held);

        // Reset with a response pending drops it.
        issue(0, 16'h0000, 64'd0, 8'h00);
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        chk("rst_pending_valid", 64'(rsp_valid), 64'd0);
        $display("txn reset-with-pending rsp_valid=%0d", rsp_valid);

`ifdef CLINT_DEBUG_STOP_EN
        held = m_mtime;
        dbg_halt = 1'b1;
        repeat (20) begin
            step();
            chk("halt_mtime", mtime, held);
        end
        dbg_halt = 1'b0;
        repeat (8) step();
        $display("txn halt held=%h now=%h", held, mtime);
`endif

        // Randomized traffic.
        addrs = '{16'h0000, 16'h0004, 16'h0008, 16'h0010, 16'h4000, 16'h4008,
                  16'h4010, 16'h4018, 16'hBFF8, 16'hBFF0, 16'h8000, 16'h4001};
        for (int c = 0; c < 600; c++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : addrs[$urandom_range(0, 11)];
            if ($urandom_range(0, 1) == 1) req_wdata = m_mtime + 64'($urandom_range(0, 8));
            else req_wdata = {$urandom, $urandom};
            req_wstrb = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef CLINT_DEBUG_STOP_EN
            dbg_halt  = ($urandom_range(0, 7) == 0);
`endif
            step();
            if (c % 50 == 0)
                $display("txn rand%0d mtime=%h mtip=%b msip=%b", c, mtime, mtip, msip);
        end
        req_valid = 1'b0;
        dbg_halt = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
